// File: rtl/riskbes_pkg.sv
// Shared definitions for the riskbes 5-stage pipeline.
package riskbes_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        StResetWait,
        StFetch
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} pairs feeding the IF/ID register; flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       push_pc_i,
    input  logic [Width-1:0]       push_instr_i,
    input  logic                   pop_i,
    output logic [$clog2(Depth):0] count_o,
    output logic                   empty_o,
    output logic [Width-1:0]       head_pc_o,
    output logic [Width-1:0]       head_instr_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] r_pc_mem    [Depth];
    logic [Width-1:0] r_instr_mem [Depth];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop_i)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    // Storage needs no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            r_pc_mem[r_wr_ptr]    <= push_pc_i;
            r_instr_mem[r_wr_ptr] <= push_instr_i;
        end
    end

    assign count_o      = r_count;
    assign empty_o      = (r_count == '0);
    assign head_pc_o    = r_pc_mem[r_rd_ptr];
    assign head_instr_o = r_instr_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues in-order word requests under a credit limit, tags responses with their PC,
// buffers them for IF/ID and discards responses belonging to a stream killed by a redirect.
module instruction_fetch_unit #(
    parameter int unsigned        XLEN       = riskbes_pkg::XLEN,
    parameter logic [XLEN-1:0]    RESET_PC   = '0,
    parameter int unsigned        FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    import riskbes_pkg::*;

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CntW-1:0] r_outstanding;
    logic [CntW-1:0] r_drop_cnt;
    logic [CntW-1:0] w_fifo_count;
    logic [CntW-1:0] w_in_flight;
    logic [CntW:0]   w_credit_sum;
    logic            w_req_hs;
    logic            w_rsp;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_empty;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_instr;
    logic [XLEN-1:0] w_redirect_pc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= StResetWait;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StResetWait: w_state_next = StFetch;
            StFetch:     w_state_next = StFetch;
            default:     w_state_next = StResetWait;
        endcase
    end

    // Credit covers buffered plus in-flight entries so a returning response always has room.
    assign w_credit_sum     = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign imem_req_valid_o = (r_state == StFetch) && (w_credit_sum < (CntW+1)'(FIFO_DEPTH));
    assign imem_req_addr_o  = r_fetch_pc;

    assign w_req_hs      = imem_req_valid_o && imem_req_ready_i;
    assign w_rsp         = imem_rsp_valid_i && (r_outstanding != '0);
    assign w_push        = w_rsp && !redirect_valid_i && (r_drop_cnt == '0);
    assign w_pop         = !w_fifo_empty && !stall_i && !redirect_valid_i;
    assign w_in_flight   = r_outstanding + CntW'(w_req_hs) - CntW'(w_rsp);
    assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_in_flight;
            if (redirect_valid_i) begin
                // Everything still in flight, including a request accepted now, is old-stream.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop_cnt <= w_in_flight;
            end else begin
                if (w_req_hs) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_push)   r_rsp_pc   <= r_rsp_pc + XLEN'(4);
                if (w_rsp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CntW'(1);
            end
        end
    end

    fetch_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (XLEN)
    ) u_fetch_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (redirect_valid_i),
        .push_i       (w_push),
        .push_pc_i    (r_rsp_pc),
        .push_instr_i (imem_rsp_data_i),
        .pop_i        (w_pop),
        .count_o      (w_fifo_count),
        .empty_o      (w_fifo_empty),
        .head_pc_o    (w_head_pc),
        .head_instr_o (w_head_instr)
    );

    assign instr_valid_o = !w_fifo_empty;
    assign instr_o       = w_fifo_empty ? XLEN'(NOP_INSTR) : w_head_instr;
    assign pc_o          = w_fifo_empty ? '0 : w_head_pc;

`ifndef SYNTHESIS
    rsp_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rsp_valid_i |-> (r_outstanding != '0));
`endif

endmodule
